test_status_monitor: RTL and testbench

TEST_STATUS_MONITOR -- requirements
Module: test_status_monitor

---
 rtl/test_status_monitor.sv | 108 ++++++++++
 tb/tb_test_status_monitor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/test_status_monitor.sv
// Snoops a core's data bus for end-of-test flag/result writes and tracks run
// progress: completion, timeout, and instruction-fetch stalls.
module test_status_monitor #(
  parameter logic [31:0] FLAG_ADDR      = 32'h0000_1000,
  parameter logic [31:0] RESULT_ADDR    = 32'h0000_1004,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000,
  parameter logic [15:0] STALL_CYCLES   = 16'd64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_enable_i,
  input  logic        data_req_i,
  input  logic        data_gnt_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] mem_flag_o,
  output logic [31:0] mem_result_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic        stall_o,
  output logic [31:0] cycle_count_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TIMEOUT} state_t;

  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;

  state_t      state, next_state;
  logic [15:0] stall_cnt;
  logic [31:0] prev_addr;
  logic        wr_accept, flag_hit, result_hit, flag_set, addr_same;
  logic [31:0] flag_merged, result_merged;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int k = 0; k < 4; k++)
      if (be[k]) res[8*k +: 8] = wdata[8*k +: 8];
    return res;
  endfunction

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    wr_accept     = (state == S_RUN) && data_req_i && data_gnt_i && data_we_i;
    flag_hit      = wr_accept && (data_addr_i[31:2] == FLAG_ADDR[31:2]);
    result_hit    = wr_accept && (data_addr_i[31:2] == RESULT_ADDR[31:2]);
    flag_merged   = merge_bytes(mem_flag_o, data_wdata_i, data_be_i);
    result_merged = merge_bytes(mem_result_o, data_wdata_i, data_be_i);
    flag_set      = flag_hit && (flag_merged != 32'd0);
    addr_same     = (instr_addr_i == prev_addr);
    next_state    = state;
    case (state)
      S_IDLE: if (fetch_enable_i) next_state = S_RUN;
      // A completing flag write takes priority over an expiring timeout.
      S_RUN: begin
        if (flag_set)                          next_state = S_DONE;
        else if (cycle_count_o == TIMEOUT_LAST) next_state = S_TIMEOUT;
      end
      default: next_state = state;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      mem_flag_o    <= '0;
      mem_result_o  <= '0;
      cycle_count_o <= '0;
      stall_cnt     <= '0;
      stall_o       <= 1'b0;
      prev_addr     <= '0;
    end else begin
      state     <= next_state;
      prev_addr <= instr_addr_i;

      if (flag_hit)   mem_flag_o   <= flag_merged;
      if (result_hit) mem_result_o <= result_merged;

      // The counter only advances on edges that keep the run going, so it
      // reads back the last RUN cycle index once DONE/TIMEOUT is reached.
      if (state == S_IDLE)
        cycle_count_o <= '0;
      else if (state == S_RUN && next_state == S_RUN && cycle_count_o != 32'hFFFF_FFFF)
        cycle_count_o <= cycle_count_o + 32'd1;

      if (state == S_IDLE) begin
        stall_cnt <= '0;
      end else if (state == S_RUN) begin
        if (!addr_same)
          stall_cnt <= '0;
        else if (stall_cnt != 16'hFFFF) begin
          stall_cnt <= stall_cnt + 16'd1;
          if (stall_cnt + 16'd1 == STALL_CYCLES) stall_o <= 1'b1;
        end
      end
    end
  end

  assign done_o    = (state == S_DONE);
  assign timeout_o = (state == S_TIMEOUT);

endmodule

// File: tb/tb_test_status_monitor.sv
// Directed bench for test_status_monitor: completion, byte merge, timeout,
// stall detection, timeout/done race and mid-run reset.
module tb_test_status_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_enable;
  logic        data_req, data_gnt, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, instr_addr;
  logic [31:0] mem_flag, mem_result, cycle_count;
  logic        done, timeout, stall;

  int checks = 0;
  int errors = 0;

  test_status_monitor dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .fetch_enable_i (fetch_enable),
    .data_req_i     (data_req),
    .data_gnt_i     (data_gnt),
    .data_we_i      (data_we),
    .data_be_i      (data_be),
    .data_addr_i    (data_addr),
    .data_wdata_i   (data_wdata),
    .instr_addr_i   (instr_addr),
    .mem_flag_o     (mem_flag),
    .mem_result_o   (mem_result),
    .done_o         (done),
    .timeout_o      (timeout),
    .stall_o        (stall),
    .cycle_count_o  (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fetch_enable = 1'b0;
    data_req = 1'b0; data_gnt = 1'b0; data_we = 1'b0;
    data_be = 4'h0; data_addr = '0; data_wdata = '0; instr_addr = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic start_run();
    fetch_enable = 1'b1;
    tick();
    fetch_enable = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic gnt, input logic we);
    data_req = 1'b1; data_gnt = gnt; data_we = we;
    data_addr = addr; data_wdata = wdata; data_be = be;
    tick();
    data_req = 1'b0; data_gnt = 1'b0; data_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (mem_flag !== 32'd0) begin errors++; $display("FAIL reset_flag: got %h expected %h", mem_flag, 32'd0); end
    checks++; if (mem_result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected %h", mem_result, 32'd0); end
    checks++; if ({done, timeout, stall} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b expected 000", {done, timeout, stall}); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", cycle_count); end
  endtask

  task automatic test_basic_done();
    do_reset();
    start_run();
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL basic_count_start: got %0d expected 0", cycle_count); end
    bus_write(32'h1004, 32'd42, 4'hF, 1'b1, 1'b1);
    checks++; if (mem_result !== 32'd42) begin errors++; $display("FAIL basic_result: got %0d expected 42", mem_result); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_not_done: got %b expected 0", done); end
    bus_write(32'h1000, 32'd1, 4'hF, 1'b1, 1'b1);
    checks++; if (mem_flag !== 32'd1) begin errors++; $display("FAIL basic_flag: got %h expected 1", mem_flag); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", done); end
    checks++; if (cycle_count !== 32'd1) begin errors++; $display("FAIL basic_count_at_done: got %0d expected 1", cycle_count); end
    bus_write(32'h1004, 32'd7, 4'hF, 1'b1, 1'b1);
    repeat (4) tick();
    checks++; if (mem_result !== 32'd42) begin errors++; $display("FAIL basic_write_in_done: got %0d expected 42", mem_result); end
    checks++; if (cycle_count !== 32'd1) begin errors++; $display("FAIL basic_count_frozen: got %0d expected 1", cycle_count); end
    checks++; if ({done, timeout} !== 2'b10) begin errors++; $display("FAIL basic_status_hold: got %b expected 10", {done, timeout}); end
  endtask

  task automatic test_byte_merge();
    do_reset();
    start_run();
    bus_write(32'h1000, 32'd5, 4'hF, 1'b0, 1'b1);
    checks++; if (mem_flag !== 32'd0) begin errors++; $display("FAIL merge_no_gnt: got %h expected 0", mem_flag); end
    bus_write(32'h1000, 32'd5, 4'hF, 1'b1, 1'b0);
    checks++; if (mem_flag !== 32'd0 || done !== 1'b0) begin errors++; $display("FAIL merge_read: got flag %h done %b expected 0 0", mem_flag, done); end
    bus_write(32'h1006, 32'h0000_0011, 4'b0001, 1'b1, 1'b1);
    checks++; if (mem_result !== 32'h11) begin errors++; $display("FAIL merge_low_addr_bits: got %h expected 11", mem_result); end
    bus_write(32'h1004, 32'hFFFF_FFFF, 4'b0000, 1'b1, 1'b1);
    checks++; if (mem_result !== 32'h11) begin errors++; $display("FAIL merge_be_zero: got %h expected 11", mem_result); end
    bus_write(32'h1007, 32'hAABB_CCDD, 4'b1100, 1'b1, 1'b1);
    checks++; if (mem_result !== 32'hAABB_0011) begin errors++; $display("FAIL merge_upper_bytes: got %h expected aabb0011", mem_result); end
    bus_write(32'h1000, 32'd0, 4'hF, 1'b1, 1'b1);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL merge_zero_flag: got done %b expected 0", done); end
    bus_write(32'h1000, 32'h0000_AB00, 4'b0010, 1'b1, 1'b1);
    checks++; if (mem_flag !== 32'h0000_AB00) begin errors++; $display("FAIL merge_flag_byte1: got %h expected 0000ab00", mem_flag); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL merge_done: got %b expected 1", done); end
  endtask

  task automatic test_timeout();
    do_reset();
    start_run();
    repeat (999) tick();
    checks++; if (timeout !== 1'b0 || cycle_count !== 32'd999) begin errors++; $display("FAIL timeout_early: got to %b count %0d expected 0 999", timeout, cycle_count); end
    tick();
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b expected 1", timeout); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL timeout_done: got %b expected 0", done); end
    bus_write(32'h1000, 32'd1, 4'hF, 1'b1, 1'b1);
    repeat (3) tick();
    checks++; if (cycle_count !== 32'd999) begin errors++; $display("FAIL timeout_count_frozen: got %0d expected 999", cycle_count); end
    checks++; if ({done, timeout} !== 2'b01 || mem_flag !== 32'd0) begin errors++; $display("FAIL timeout_sticky: got %b flag %h expected 01 0", {done, timeout}, mem_flag); end
  endtask

  task automatic test_stall();
    do_reset();
    instr_addr = 32'h0000_0200;
    start_run();
    repeat (63) tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_early: got %b expected 0", stall); end
    tick();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_set: got %b expected 1", stall); end
    checks++; if ({done, timeout} !== 2'b00 || cycle_count !== 32'd64) begin errors++; $display("FAIL stall_still_run: got %b count %0d expected 00 64", {done, timeout}, cycle_count); end
    instr_addr = 32'h0000_0300;
    repeat (5) tick();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_sticky: got %b expected 1", stall); end

    do_reset();
    instr_addr = 32'h0000_0200;
    start_run();
    repeat (62) tick();
    instr_addr = 32'h0000_0204;
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_change63: got %b expected 0", stall); end
    repeat (40) tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_restarted: got %b expected 0", stall); end
  endtask

  task automatic test_timeout_race();
    do_reset();
    start_run();
    repeat (999) tick();
    bus_write(32'h1000, 32'h8000_0000, 4'hF, 1'b1, 1'b1);
    checks++; if ({done, timeout} !== 2'b10) begin errors++; $display("FAIL race_done_wins: got %b expected 10", {done, timeout}); end
    repeat (3) tick();
    checks++; if (timeout !== 1'b0 || cycle_count !== 32'd999) begin errors++; $display("FAIL race_hold: got to %b count %0d expected 0 999", timeout, cycle_count); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    instr_addr = 32'h0000_0400;
    start_run();
    bus_write(32'h1004, 32'h55, 4'hF, 1'b1, 1'b1);
    repeat (70) tick();
    checks++; if (cycle_count !== 32'd71 || stall !== 1'b1) begin errors++; $display("FAIL midrst_pre: got count %0d stall %b expected 71 1", cycle_count, stall); end
    rst = 1'b1;
    #1;
    checks++; if (mem_result !== 32'd0 || cycle_count !== 32'd0 || {done, timeout, stall} !== 3'b000) begin
      errors++; $display("FAIL midrst_clear: got result %h count %0d status %b expected 0 0 000", mem_result, cycle_count, {done, timeout, stall}); end
    #2;
    rst = 1'b0;
    repeat (3) tick();
    bus_write(32'h1000, 32'd1, 4'hF, 1'b1, 1'b1);
    checks++; if (cycle_count !== 32'd0 || mem_flag !== 32'd0 || done !== 1'b0) begin
      errors++; $display("FAIL midrst_idle: got count %0d flag %h done %b expected 0 0 0", cycle_count, mem_flag, done); end
    start_run();
    tick();
    checks++; if (cycle_count !== 32'd1) begin errors++; $display("FAIL midrst_rerun: got %0d expected 1", cycle_count); end
  endtask

  initial begin
    test_reset();
    test_basic_done();
    test_byte_merge();
    test_timeout();
    test_stall();
    test_timeout_race();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
